// File: rtl/level_bar_pkg.sv
// Shared constants and helpers for the level bar display controller.
package level_bar_pkg;

    // Display mode select values
    localparam logic MODE_BAR = 1'b0;
    localparam logic MODE_DOT = 1'b1;

    // Width needed to hold counts 0..n-1, never less than one bit
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/level_bar_ctrl_therm_dec.sv
// Combinational level-code decoder: thermometer (bar) or one-hot (dot).
module therm_dec
    import level_bar_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]      code_i,
    input  logic                  mode_i,
    output logic [2**WIDTH-1:0]   vec_o
);

    localparam int DISP_W = 2**WIDTH;

    // Each output bit compares its own index against the code
    always_comb begin
        vec_o = '0;
        for (int i = 0; i < DISP_W; i++) begin
            if (mode_i == MODE_DOT) begin
                vec_o[i] = (code_i == i[WIDTH-1:0]);
            end else begin
                vec_o[i] = (code_i >= i[WIDTH-1:0]);
            end
        end
    end

endmodule

// File: rtl/level_bar_ctrl.sv
// Level meter controller: captures a level code, tracks a held and
// slowly decaying peak, and drives a bar or dot display vector.
// en_i is a plain capture strobe: level_i is taken on every rising edge
// where en_i is high; there is no back-pressure.
module level_bar_ctrl
    import level_bar_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int DECAY_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic [WIDTH-1:0]      level_i,
    input  logic                  mode_i,
    input  logic                  peak_en_i,
    input  logic                  clear_i,
    output logic [2**WIDTH-1:0]   disp_o,
    output logic [WIDTH-1:0]      cur_o,
    output logic [WIDTH-1:0]      peak_o,
    output logic                  valid_o
);

    localparam int DISP_W = 2**WIDTH;
    localparam int HW     = cnt_w(HOLD_CYCLES + 1);
    localparam int DW     = cnt_w(DECAY_CYCLES);

    logic [WIDTH-1:0] cur_q,   cur_d;
    logic [WIDTH-1:0] peak_q,  peak_d;
    logic             valid_q, valid_d;
    logic [HW-1:0]    hold_q,  hold_d;
    logic [DW-1:0]    decay_q, decay_d;

    logic              peak_cap;
    logic [DISP_W-1:0] dec_vec;
    logic [DISP_W-1:0] peak_mask;

    // Next-state: capture, then peak capture > hold countdown > decay
    always_comb begin
        cur_d    = cur_q;
        valid_d  = valid_q;
        peak_d   = peak_q;
        hold_d   = hold_q;
        decay_d  = decay_q;
        peak_cap = en_i && ((level_i >= peak_q) || !valid_q);

        if (en_i) begin
            cur_d   = level_i;
            valid_d = 1'b1;
        end

        if (peak_cap) begin
            peak_d  = level_i;
            hold_d  = HW'(HOLD_CYCLES);
            decay_d = '0;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end else if (peak_q > cur_q) begin
            // Decrementing only while peak > cur keeps peak >= cur and >= 0
            if (decay_q == DW'(DECAY_CYCLES - 1)) begin
                peak_d  = peak_q - 1'b1;
                decay_d = '0;
            end else begin
                decay_d = decay_q + 1'b1;
            end
        end
    end

    // All state: async reset, then synchronous clear, then next-state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q   <= '0;
            peak_q  <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            decay_q <= '0;
        end else if (clear_i) begin
            cur_q   <= '0;
            peak_q  <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            decay_q <= '0;
        end else begin
            cur_q   <= cur_d;
            peak_q  <= peak_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            decay_q <= decay_d;
        end
    end

    therm_dec #(.WIDTH(WIDTH)) u_cur_dec (
        .code_i (cur_q),
        .mode_i (mode_i),
        .vec_o  (dec_vec)
    );

    assign peak_mask = {{(DISP_W-1){1'b0}}, 1'b1} << peak_q;

    // Display: blank until valid, optional peak marker OR-ed on top
    always_comb begin
        disp_o = '0;
        if (valid_q) begin
            disp_o = dec_vec;
            if (peak_en_i) begin
                disp_o = disp_o | peak_mask;
            end
        end
    end

    assign cur_o   = cur_q;
    assign peak_o  = peak_q;
    assign valid_o = valid_q;

endmodule

// File: doc/level_bar_ctrl.md
LEVEL_BAR_CTRL -- requirements
Module: level_bar_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: level code width; display width is 2**WIDTH.
REQ-002 Parameter HOLD_CYCLES, default 8: clk cycles the peak is held after a new peak (>=1).
REQ-003 Parameter DECAY_CYCLES, default 4: clk cycles per one-step peak decrement (>=1).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  capture strobe; level is sampled on clk edges where en=1.
REQ-007 level  in  WIDTH  level code to display.
REQ-008 mode  in  1  0 = bar (thermometer), 1 = dot (one-hot).
REQ-009 peak_en  in  1  1 = overlay peak marker bit on disp.
REQ-010 clear  in  1  synchronous clear of all state.
REQ-011 disp  out  2**WIDTH  display vector.
REQ-012 cur  out  WIDTH  registered current level.
REQ-013 peak  out  WIDTH  registered peak-hold level.
REQ-014 valid  out  1  1 once a level has been captured since reset/clear.

Function
REQ-015 On an edge with en=1 and clear=0: cur <= level, valid <= 1; one-cycle latency to disp.
REQ-016 On an edge with en=0: cur and valid hold their value.
REQ-017 disp is a combinational decode of registered cur, peak, valid and live mode/peak_en; a mode change is visible the same cycle.
REQ-018 valid=0: disp = all zeros regardless of other inputs.
REQ-019 Bar mode: disp[i]=1 for all i<=cur, else 0 (cur=0 gives 0x0001; cur=15 gives 0xFFFF at WIDTH=4).
REQ-020 Dot mode: disp[cur]=1 only.
REQ-021 peak_en=1 and valid=1: disp[peak] is additionally forced to 1 (OR overlay).
REQ-022 Peak capture: on an en edge with level>=peak (or valid=0): peak <= level, hold_cnt <= HOLD_CYCLES, decay_cnt <= 0.
REQ-023 Hold phase: each edge with hold_cnt>0 and no peak capture decrements hold_cnt by 1.
REQ-024 Decay phase: hold_cnt=0 and peak>cur: decay_cnt increments each edge; when decay_cnt=DECAY_CYCLES-1, peak <= peak-1 and decay_cnt <= 0.
REQ-025 Decay stops when peak=cur; peak never goes below cur and never wraps below 0.
REQ-026 Priority per edge: reset > clear > peak capture > hold countdown > decay.
REQ-027 A new capture with level<peak updates cur only; hold/decay continue undisturbed.
REQ-028 Counters are unsigned, sized $clog2(HOLD_CYCLES+1) and $clog2(DECAY_CYCLES) (min 1 bit); no overflow is possible.

Reset
REQ-029 reset=1 asynchronously forces cur=0, peak=0, valid=0, hold_cnt=0, decay_cnt=0, hence disp=0.
REQ-030 clear=1 at an edge produces the same state as reset, overriding a simultaneous en.
REQ-031 Reset or clear mid-hold or mid-decay abandons the sequence; no residual peak remains.

Structure
REQ-032 Shared package level_bar_pkg holds the mode constants MODE_BAR=0, MODE_DOT=1.
REQ-033 Sub-module therm_dec (parametrised WIDTH): combinational code-to-thermometer/one-hot decoder, instantiated once for cur; the peak overlay is a separate one-hot OR.
REQ-034 All state elements are in a single clocked process with asynchronous reset; no latches.

Verification (WIDTH=4, HOLD_CYCLES=8, DECAY_CYCLES=4)
REQ-035 Reset, then en=1 level=3 mode=0 for one edge -> disp=0x000F, cur=3, valid=1; with en low afterwards, disp holds.
REQ-036 level=15 bar -> disp=0xFFFF; switch mode=1 with cur=5 -> disp=0x0020 the same cycle.
REQ-037 Capture 12 at edge k, capture 4 at k+1 -> peak=12 through edge k+8, 11 at k+12, 10 at k+16, 4 at k+40, then stays 4.
REQ-038 Dot mode, peak_en=1, cur=4, peak=12 -> disp=0x1010; peak_en=0 -> disp=0x0010.
REQ-039 During decay (peak=9, cur=2), en level=14 -> peak=14 next edge, hold restarts; en level=13 -> cur=13 and peak stays 14.
REQ-040 clear and en at the same edge -> all outputs 0, valid=0; reset asserted mid-decay, async between edges -> disp=0 immediately.
